// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for the RV32IM execute stage.
// Fixed WIDTH+1 cycle latency from accept to done_o; stalls the pipeline while iterating.
module div_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [4:0]       rd_i,
    input  logic             flush_i,
    output logic             ex_stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_CNT = 6'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [5:0]       cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] divisor_q;
    logic             rem_sel_q;
    logic             qneg_q;
    logic             rneg_q;
    logic [4:0]       rd_q;

    logic             accept;
    logic             signed_op;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign accept    = start_i && !flush_i && (state_q != S_CALC);
    assign signed_op = ~op_i[0];
    assign a_abs     = (signed_op && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_abs     = (signed_op && b_i[WIDTH-1]) ? -b_i : b_i;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted[WIDTH:0] - {1'b0, divisor_q};
    assign ge      = (shifted >= {2'b00, divisor_q});
    assign rem_nxt = ge ? diff : shifted[WIDTH:0];
    assign quo_nxt = {quo_q[WIDTH-2:0], ge};
    assign q_fix   = qneg_q ? -quo_nxt : quo_nxt;
    assign r_fix   = rneg_q ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];

    assign ex_stall_o = (state_q == S_CALC);
    assign done_o     = (state_q == S_DONE);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_i && !flush_i) state_d = S_CALC;
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = (start_i && !flush_i) ? S_CALC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divide-by-zero leaves the quotient as all ones (no negation); the remainder
    // path naturally yields |a| which rneg turns back into a.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            rem_sel_q <= 1'b0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            rd_q      <= '0;
            result_o  <= '0;
            rd_o      <= '0;
        end else if (accept) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= a_abs;
            divisor_q <= b_abs;
            rem_sel_q <= op_i[1];
            qneg_q    <= signed_op && (a_i[WIDTH-1] ^ b_i[WIDTH-1]) && (b_i != '0);
            rneg_q    <= signed_op && a_i[WIDTH-1];
            rd_q      <= rd_i;
        end else if (state_q == S_CALC && !flush_i) begin
            cnt_q <= cnt_q + 6'd1;
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            if (cnt_q == LAST_CNT) begin
                result_o <= rem_sel_q ? r_fix : q_fix;
                rd_o     <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: cycle-level reference model plus
// directed RV32M divide vectors with hand-computed results.
module tb_div_sequencer;

    localparam int unsigned W = 32;

    logic          clk_i = 1'b0;
    logic          reset_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    op_i = '0;
    logic [W-1:0]  a_i = '0;
    logic [W-1:0]  b_i = '0;
    logic [4:0]    rd_i = '0;
    logic          flush_i = 1'b0;
    logic          ex_stall_o;
    logic          done_o;
    logic [W-1:0]  result_o;
    logic [4:0]    rd_o;

    div_sequencer #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .rd_i       (rd_i),
        .flush_i    (flush_i),
        .ex_stall_o (ex_stall_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_o       (rd_o)
    );

    always #5 clk_i = ~clk_i;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // RISC-V M semantics from plain arithmetic.
    function automatic logic [31:0] model_calc(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
            return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return op[1] ? a % b : a / b;
    endfunction

    // Timeline model: a busy countdown of W cycles after each accepted op.
    int           m_busy = 0;
    logic         m_done = 1'b0;
    logic [31:0]  m_res  = '0;
    logic [31:0]  m_pend = '0;
    logic [4:0]   m_rd   = '0;
    logic [4:0]   m_prd  = '0;

    always @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            m_busy = 0; m_done = 1'b0; m_res = '0; m_rd = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy > 0) begin
                if (flush_i) m_busy = 0;
                else begin
                    m_busy--;
                    if (m_busy == 0) begin
                        m_done = 1'b1; m_res = m_pend; m_rd = m_prd;
                    end
                end
            end else if (start_i && !flush_i) begin
                m_busy = W;
                m_pend = model_calc(op_i, a_i, b_i);
                m_prd  = rd_i;
            end
        end
    end

    always @(negedge clk_i) begin
        if (reset_ni) begin
            check("stall", 32'(ex_stall_o), 32'(m_busy > 0));
            check("done", 32'(done_o), 32'(m_done));
            check("result", result_o, m_res);
            check("rd", 32'(rd_o), 32'(m_rd));
        end
    end

    // Called at a negedge that is cycle 1 after accept; returns on done_o or budget.
    task automatic wait_done(output int lat, output int stalls);
        lat = 0; stalls = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done_o) begin lat = k; break; end
            if (ex_stall_o) stalls++;
            @(negedge clk_i);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; a_i = a; b_i = b; rd_i = rd;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [11] = '{
        '{2'b00, 32'd100,        32'd7,          5'd5,  32'd14},
        '{2'b10, 32'd100,        32'd7,          5'd6,  32'd2},
        '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD},
        '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF},
        '{2'b01, 32'hFFFF_FFF9,  32'd2,          5'd9,  32'h7FFF_FFFC},
        '{2'b00, 32'd42,         32'd0,          5'd10, 32'hFFFF_FFFF},
        '{2'b11, 32'd42,         32'd0,          5'd11, 32'd42},
        '{2'b10, 32'hFFFF_FFD6,  32'd0,          5'd12, 32'hFFFF_FFD6},
        '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000},
        '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0},
        '{2'b00, 32'd7,          32'hFFFF_FFFE,  5'd31, 32'hFFFF_FFFD}
    };

    initial begin
        int lat, stalls, dones;
        logic [31:0] held;

        repeat (2) @(negedge clk_i);
        check("rst_stall", 32'(ex_stall_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_rd", 32'(rd_o), 32'd0);
        reset_ni = 1'b1;

        foreach (vecs[i]) begin
            check("model_pin", model_calc(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            wait_done(lat, stalls);
            check("latency", 32'(lat), 32'd33);
            check("stall_cycles", 32'(stalls), 32'd32);
            check("vec_result", result_o, vecs[i].exp);
            check("vec_rd", 32'(rd_o), 32'(vecs[i].rd));
        end

        // Back-to-back: second op presented in the DONE cycle.
        issue(2'b01, 32'd1000, 32'd10, 5'd3);
        wait_done(lat, stalls);
        check("b2b_first", result_o, 32'd100);
        start_i = 1'b1; op_i = 2'b10; a_i = 32'd1000; b_i = 32'hFFFF_FFF9; rd_i = 5'd4;
        @(negedge clk_i);
        start_i = 1'b0;
        check("b2b_no_idle", 32'(ex_stall_o), 32'd1);
        wait_done(lat, stalls);
        check("b2b_spacing", 32'(lat), 32'd33);
        check("b2b_stalls", 32'(stalls), 32'd32);
        check("b2b_second", result_o, 32'd6);
        check("b2b_rd", 32'(rd_o), 32'd4);

        // Flush mid-CALC aborts with no completion.
        held = result_o;
        issue(2'b00, 32'd500, 32'd5, 5'd20);
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_idle", 32'(ex_stall_o), 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        check("flush_no_done", 32'(dones), 32'd0);
        check("flush_hold", result_o, held);

        // Start with flush in IDLE is not accepted.
        start_i = 1'b1; flush_i = 1'b1; op_i = 2'b00; a_i = 32'd9; b_i = 32'd3;
        @(negedge clk_i);
        start_i = 1'b0; flush_i = 1'b0;
        check("startflush_rej", 32'(ex_stall_o), 32'd0);
        repeat (3) @(negedge clk_i);

        // Asynchronous reset mid-CALC.
        issue(2'b00, 32'd77, 32'd7, 5'd9);
        repeat (5) @(negedge clk_i);
        #2 reset_ni = 1'b0;
        #1;
        check("areset_stall", 32'(ex_stall_o), 32'd0);
        check("areset_done", 32'(done_o), 32'd0);
        check("areset_result", result_o, 32'd0);
        check("areset_rd", 32'(rd_o), 32'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        check("post_reset_stall", 32'(ex_stall_o), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
